// File: rtl/dvi_twi_config.sv
// dvi_twi_config: write-only I2C master that streams a {regAddr, value}
// table from an external ROM into the DVI transmitter, one write per entry.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | bus released, waiting for iStart
// S_FETCH | oTableAddr driven, two clocks for ROM data
// S_START | START condition (SDA falls while SCL high)
// S_SHIFT | eight data bits, MSB first
// S_ACK   | ninth bit, SDA released, slave ACK/NACK sampled
// S_STOP  | STOP condition (SDA rises while SCL high)
// S_GAP   | idle quarters between entries
// S_DONE  | all entries ACKed, oDone sticky
// S_ERROR | a byte was NACKed, oError sticky
module dvi_twi_config #(
  parameter int unsigned CLK_DIV      = 125,
  parameter logic [6:0]  DEV_ADDR     = 7'h76,
  parameter int unsigned NUM_ENTRIES  = 8,
  parameter int unsigned GAP_QUARTERS = 8
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStart,
  output logic [7:0]  oTableAddr,
  input  logic [15:0] iTableData,
  input  logic        iSda,
  input  logic        iScl,
  output logic        oSda,
  output logic        oScl,
  output logic        oBusy,
  output logic        oDone,
  output logic        oError,
  output logic [7:0]  oFailIdx
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_START, S_SHIFT, S_ACK, S_STOP, S_GAP, S_DONE, S_ERROR
  } state_t;

  localparam logic [9:0] PRESC_MAX = 10'(CLK_DIV - 1);
  localparam logic [7:0] LAST_IDX  = 8'(NUM_ENTRIES - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_QUARTERS - 1);

  state_t      state_q;
  logic [1:0]  phase_q;
  logic [7:0]  idx_q;
  logic [1:0]  byte_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic [7:0]  reg_q;
  logic [7:0]  val_q;
  logic        fetch_q;
  logic [7:0]  gap_q;
  logic        nack_q;
  logic        abort_q;
  logic        scl_q;
  logic        sda_q;
  logic        busy_q;
  logic        done_q;
  logic        error_q;
  logic [7:0]  fail_q;
  logic [9:0]  presc_q;
  logic [9:0]  presc_d;
  logic        bus_active;
  logic        stretch;
  logic        tick;
  logic [7:0]  next_byte;

  // Line levels {scl, sda} for a given state and quarter.
  function automatic logic [1:0] lines(input state_t st, input logic [1:0] ph,
                                       input logic bit_v);
    logic [1:0] l;
    l = 2'b11;
    case (st)
      S_START: l = (ph == 2'd0 || ph == 2'd1) ? 2'b11 : ((ph == 2'd2) ? 2'b10 : 2'b00);
      S_SHIFT: l = {ph[1], bit_v};
      S_ACK:   l = {ph[1], 1'b1};
      S_STOP:  l = (ph == 2'd0) ? 2'b00 : ((ph == 2'd3) ? 2'b11 : 2'b10);
      default: l = 2'b11;
    endcase
    return l;
  endfunction

  assign bus_active = (state_q == S_START) || (state_q == S_SHIFT) || (state_q == S_ACK) ||
                      (state_q == S_STOP)  || (state_q == S_GAP);
  // A released SCL still read low means the slave is stretching the clock.
  assign stretch    = scl_q & ~iScl;
  assign tick       = bus_active & ~stretch & (presc_q == PRESC_MAX);
  assign next_byte  = (byte_q == 2'd0) ? reg_q : val_q;

  // Next prescaler value: restarts at every quarter and is pinned at 0 during a stretch.
  always_comb begin
    presc_d = presc_q + 10'd1;
    if (!bus_active || stretch || tick) presc_d = '0;
  end

  // Quarter-period prescaler register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) presc_q <= '0;
    else      presc_q <= presc_d;
  end

  // Sequencer: walks the table and generates the bus waveform quarter by quarter.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      reg_q   <= '0;
      val_q   <= '0;
      fetch_q <= 1'b0;
      gap_q   <= '0;
      nack_q  <= 1'b0;
      abort_q <= 1'b0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      fail_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (iStart) begin
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            idx_q   <= '0;
            fetch_q <= 1'b0;
            abort_q <= 1'b0;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          fetch_q <= ~fetch_q;
          if (fetch_q) begin
            reg_q          <= iTableData[15:8];
            val_q          <= iTableData[7:0];
            phase_q        <= '0;
            {scl_q, sda_q} <= 2'b11;
            state_q        <= S_START;
          end
        end
        S_START, S_SHIFT, S_ACK, S_STOP: begin
          if (tick) begin
            if (phase_q != 2'd3) begin
              phase_q        <= phase_q + 2'd1;
              {scl_q, sda_q} <= lines(state_q, phase_q + 2'd1, shift_q[7]);
              if (state_q == S_ACK && phase_q == 2'd2) nack_q <= iSda;
            end else begin
              phase_q <= '0;
              case (state_q)
                S_START: begin
                  shift_q        <= {DEV_ADDR, 1'b0};
                  byte_q         <= '0;
                  bit_q          <= '0;
                  {scl_q, sda_q} <= {1'b0, DEV_ADDR[6]};
                  state_q        <= S_SHIFT;
                end
                S_SHIFT: begin
                  if (bit_q == 3'd7) begin
                    {scl_q, sda_q} <= 2'b01;
                    state_q        <= S_ACK;
                  end else begin
                    bit_q          <= bit_q + 3'd1;
                    shift_q        <= {shift_q[6:0], 1'b0};
                    {scl_q, sda_q} <= {1'b0, shift_q[6]};
                  end
                end
                S_ACK: begin
                  if (nack_q || byte_q == 2'd2) begin
                    if (nack_q) begin
                      fail_q  <= idx_q;
                      abort_q <= 1'b1;
                    end
                    {scl_q, sda_q} <= 2'b00;
                    state_q        <= S_STOP;
                  end else begin
                    byte_q         <= byte_q + 2'd1;
                    bit_q          <= '0;
                    shift_q        <= next_byte;
                    {scl_q, sda_q} <= {1'b0, next_byte[7]};
                    state_q        <= S_SHIFT;
                  end
                end
                default: begin
                  // End of STOP: lines are already released.
                  gap_q <= '0;
                  if (abort_q) begin
                    busy_q  <= 1'b0;
                    error_q <= 1'b1;
                    state_q <= S_ERROR;
                  end else begin
                    state_q <= S_GAP;
                  end
                end
              endcase
            end
          end
        end
        S_GAP: begin
          if (tick) begin
            if (gap_q == GAP_LAST) begin
              if (idx_q == LAST_IDX) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                idx_q   <= idx_q + 8'd1;
                fetch_q <= 1'b0;
                state_q <= S_FETCH;
              end
            end else begin
              gap_q <= gap_q + 8'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oTableAddr = idx_q;
  assign oSda       = sda_q;
  assign oScl       = scl_q;
  assign oBusy      = busy_q;
  assign oDone      = done_q;
  assign oError     = error_q;
  assign oFailIdx   = fail_q;

endmodule

// File: tb/tb_dvi_twi_config.sv
// Directed bench for dvi_twi_config: ROM model, ACKing/NACKing slave with
// optional clock stretch, and a bus decoder logging START/bytes/STOP.
module tb_dvi_twi_config;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iStart;
  logic [7:0]  oTableAddr;
  logic [15:0] iTableData = 16'h0000;
  logic        iSda;
  logic        iScl;
  logic        oSda;
  logic        oScl;
  logic        oBusy;
  logic        oDone;
  logic        oError;
  logic [7:0]  oFailIdx;

  int checks;
  int errors;

  logic [15:0] tab [8];
  int          cyc = 0;

  // Slave / monitor state
  logic   slave_sda = 1'b1;
  logic   mon_clr;
  logic   stretch_en;
  int     nack_entry;
  logic   prev_scl = 1'b1, prev_sda = 1'b1, prev_oscl = 1'b1;
  logic   scl_s, sda_s;
  logic [7:0] sh = 8'h00;
  int     bitcnt = 0, bytecnt = 0, starts = 0, rises = 0, hold_cnt = 0, max_addr = 0;
  int     ev_q[$];
  int     ev_t[$];
  int     fall_q[$];
  int     exp_q[$];
  logic   hold;

  dvi_twi_config #(
    .CLK_DIV(2), .DEV_ADDR(7'h76), .NUM_ENTRIES(8), .GAP_QUARTERS(8)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .oTableAddr(oTableAddr),
    .iTableData(iTableData), .iSda(iSda), .iScl(iScl), .oSda(oSda), .oScl(oScl),
    .oBusy(oBusy), .oDone(oDone), .oError(oError), .oFailIdx(oFailIdx)
  );

  always #5 iClk = ~iClk;

  always @(posedge iClk) cyc <= cyc + 1;

  // Registered ROM: data follows the address by one clock.
  always @(posedge iClk) iTableData <= tab[oTableAddr[2:0]];

  // The stretch covers 20 rising clock edges from the 13th SCL release
  // (byte 1, bit index 3, MSB-first).
  assign hold = stretch_en && oScl &&
                ((rises + ((oScl && !prev_oscl) ? 1 : 0)) == 13) && (hold_cnt <= 20);
  assign iScl = oScl & ~hold;
  assign iSda = oSda & slave_sda;

  always @(negedge iClk) begin
    if (mon_clr || iRst) begin
      ev_q.delete(); ev_t.delete(); fall_q.delete();
      bitcnt = 0; bytecnt = 0; starts = 0; rises = 0; hold_cnt = 0; max_addr = 0;
      sh = 8'h00; slave_sda = 1'b1;
      prev_scl = 1'b1; prev_sda = 1'b1; prev_oscl = 1'b1;
    end else begin
      scl_s = iScl;
      sda_s = iSda;
      if (hold) hold_cnt++;
      if (oScl && !prev_oscl) rises++;
      if (!oScl && prev_oscl) fall_q.push_back(cyc);
      prev_oscl = oScl;
      if (int'(oTableAddr) > max_addr) max_addr = int'(oTableAddr);
      if (scl_s && prev_scl && prev_sda && !sda_s) begin
        ev_q.push_back(32'h100); ev_t.push_back(cyc);
        starts++; bitcnt = 0; bytecnt = 0;
      end else if (scl_s && prev_scl && !prev_sda && sda_s) begin
        ev_q.push_back(32'h200); ev_t.push_back(cyc);
      end
      if (scl_s && !prev_scl) begin
        if (bitcnt < 8) begin
          sh = {sh[6:0], sda_s};
          bitcnt++;
          if (bitcnt == 8) begin
            ev_q.push_back(int'(sh)); ev_t.push_back(cyc);
          end
        end else begin
          bitcnt = 0;
          bytecnt++;
        end
      end
      if (!scl_s && prev_scl)
        slave_sda = (bitcnt == 8) ? ((starts - 1 == nack_entry) && (bytecnt == 1)) : 1'b1;
      prev_scl = scl_s;
      prev_sda = sda_s;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Expected decode: START, 0xEC, reg, value, STOP per entry; a NACKed
  // register byte ends that entry with STOP and the run stops there.
  task automatic build_exp(input int nack_e);
    exp_q.delete();
    for (int e = 0; e < 8; e++) begin
      exp_q.push_back(32'h100);
      exp_q.push_back(32'hEC);
      exp_q.push_back(int'(tab[e][15:8]));
      if (e == nack_e) begin
        exp_q.push_back(32'h200);
        break;
      end
      exp_q.push_back(int'(tab[e][7:0]));
      exp_q.push_back(32'h200);
    end
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_events"}, ev_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
      chk($sformatf("%s_ev%0d", tag, i), ev_q[i], exp_q[i]);
  endtask

  function automatic int fdiff(input int k);
    return (fall_q.size() > k + 1) ? fall_q[k + 1] - fall_q[k] : -1;
  endfunction

  function automatic int tdiff(input int k);
    return (ev_t.size() > k + 1) ? ev_t[k + 1] - ev_t[k] : -1;
  endfunction

  task automatic start_run();
    mon_clr = 1'b1;
    iStart  = 1'b1;
    @(negedge iClk);
    #1;
    mon_clr = 1'b0;
    iStart  = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge iClk);
      if (!oBusy) break;
    end
    chk(tag, oBusy, 1'b0);
  endtask

  initial begin
    logic found;
    checks = 0; errors = 0;
    iRst = 1'b0; iStart = 1'b0; mon_clr = 1'b0; stretch_en = 1'b0; nack_entry = -1;
    tab[0] = 16'h49C0; tab[1] = 16'h2109; tab[2] = 16'h335A; tab[3] = 16'h1DFF;
    tab[4] = 16'h4800; tab[5] = 16'h08A5; tab[6] = 16'h0E3C; tab[7] = 16'h5681;
    #2 iRst = 1'b1;
    repeat (2) @(negedge iClk);
    chk("rst_scl", oScl, 1'b1);
    chk("rst_sda", oSda, 1'b1);
    chk("rst_busy", oBusy, 1'b0);
    chk("rst_done", oDone, 1'b0);
    chk("rst_error", oError, 1'b0);
    chk("rst_failidx", oFailIdx, 8'd0);
    chk("rst_addr", oTableAddr, 8'd0);
    iRst = 1'b0;
    @(negedge iClk);

    // Run A: full 8-entry walk, all ACKed
    start_run();
    chk("A_busy_set", oBusy, 1'b1);
    wait_idle("A_timeout", 5000);
    build_exp(-1);
    check_log("A");
    chk("A_done", oDone, 1'b1);
    chk("A_error", oError, 1'b0);
    // fall_q[0] is START's SCL fall; fall_q[k], k>=1, opens bit k of the frame.
    chk("A_bit_period", fdiff(1), 8);
    chk("A_bit12_period", fdiff(12), 8);
    // STOP edge to next START edge: STOP Q3 + 8 gap quarters + START Q0,Q1
    // (11 quarters of 2 clocks) plus 2 FETCH clocks.
    for (int e = 0; e < 7; e++)
      chk($sformatf("A_gap%0d", e), tdiff(5 * e + 4), 24);

    // Run B: restart from DONE, ignored mid-run iStart, clock stretch
    stretch_en = 1'b1;
    start_run();
    chk("B_done_clr", oDone, 1'b0);
    chk("B_busy_set", oBusy, 1'b1);
    chk("B_addr0", oTableAddr, 8'd0);
    repeat (100) @(negedge iClk);
    iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    chk("B_busy_after_ignored_start", oBusy, 1'b1);
    wait_idle("B_timeout", 5000);
    check_log("B");
    chk("B_prev_bit_period", fdiff(11), 8);
    chk("B_stretched_period", fdiff(12), 28);
    chk("B_done", oDone, 1'b1);
    stretch_en = 1'b0;

    // Run C: NACK on the register byte of entry 2
    nack_entry = 2;
    start_run();
    wait_idle("C_timeout", 5000);
    build_exp(2);
    check_log("C");
    chk("C_error", oError, 1'b1);
    chk("C_failidx", oFailIdx, 8'd2);
    chk("C_done", oDone, 1'b0);
    chk("C_max_addr", max_addr, 2);
    nack_entry = -1;

    // Run D: restart from ERROR, then reset mid-byte
    start_run();
    chk("D_error_clr", oError, 1'b0);
    chk("D_busy_set", oBusy, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge iClk);
      if (oBusy && !oScl && !oSda && rises >= 3) begin
        found = 1'b1;
        break;
      end
    end
    chk("D_midbyte_found", found, 1'b1);
    #1 iRst = 1'b1;
    #1;
    chk("D_rst_scl", oScl, 1'b1);
    chk("D_rst_sda", oSda, 1'b1);
    chk("D_rst_busy", oBusy, 1'b0);
    chk("D_rst_done", oDone, 1'b0);
    chk("D_rst_error", oError, 1'b0);
    chk("D_rst_failidx", oFailIdx, 8'd0);
    chk("D_rst_addr", oTableAddr, 8'd0);
    iStart = 1'b1;
    repeat (3) @(negedge iClk);
    iStart = 1'b0;
    chk("D_start_in_rst_busy", oBusy, 1'b0);
    chk("D_start_in_rst_scl", oScl, 1'b1);
    iRst = 1'b0;
    repeat (5) @(negedge iClk);
    chk("D_post_rst_busy", oBusy, 1'b0);
    chk("D_post_rst_sda", oSda, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
